// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: base^exponent mod modulus, right-to-left square-and-multiply over one bit-serial modular multiplier.
// Define RSA_MODEXP_CONST_TIME_EN for operand-independent latency.
module rsa_modexp_engine #(
  parameter int WIDTH = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 finished,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);
  localparam int JW = $clog2(WIDTH);
  localparam int RW = $clog2(EXP_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, LOAD, DECIDE, MUL, SQR, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] m, r, bb, x, addend;
  logic [EXP_WIDTH-1:0] e;
  logic [RW-1:0] rnd;
  logic [JW-1:0] j;
  logic [WIDTH+1:0] acc, t0, t1, t2;
  logic illegal, last, rnd_end;
  assign busy = state != IDLE;
  assign finished = state == DONE;
  assign illegal = m == '0 || bb >= m;
  assign last = j == '0;
  assign rnd_end = rnd + 1'b1 == RW'(EXP_WIDTH);
  // One multiplier step: double, add partial product, reduce twice (acc < 3*modulus before reduction).
  assign x = state == MUL ? r : bb;
  assign addend = x[j] ? bb : '0;
  assign t0 = (acc << 1) + {2'b00, addend};
  assign t1 = t0 >= {2'b00, m} ? t0 - {2'b00, m} : t0;
  assign t2 = t1 >= {2'b00, m} ? t1 - {2'b00, m} : t1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = start ? LOAD : IDLE;
      LOAD:   state_nxt = illegal ? DONE : DECIDE;
`ifdef RSA_MODEXP_CONST_TIME_EN
      DECIDE: state_nxt = MUL;
`else
      DECIDE: state_nxt = e == '0 ? DONE : e[0] ? MUL : SQR;
`endif
      MUL:    state_nxt = last ? SQR : MUL;
      SQR:    state_nxt = last ? (rnd_end ? DONE : DECIDE) : SQR;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      r <= '0;
      bb <= '0;
      e <= '0;
      rnd <= '0;
      j <= '0;
      acc <= '0;
      error <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bb <= base;
          e <= exponent;
          m <= modulus;
          error <= 1'b0;
          result <= '0;
        end
        LOAD: begin
          r <= (illegal || m == WIDTH'(1)) ? '0 : WIDTH'(1);
          rnd <= '0;
          if (illegal) error <= 1'b1;
        end
        DECIDE: begin
          acc <= '0;
          j <= JW'(WIDTH - 1);
          if (state_nxt == DONE) result <= r;
        end
        MUL, SQR: begin
          acc <= last ? '0 : t2;
          j <= last ? JW'(WIDTH - 1) : j - 1'b1;
          if (last && state == MUL && e[0]) r <= t2[WIDTH-1:0];
          if (last && state == SQR) begin
            bb <= t2[WIDTH-1:0];
            e <= e >> 1;
            rnd <= rnd + 1'b1;
            if (rnd_end) result <= r;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
